// File: rtl/uart_tx_fifo.sv
// Transmit FIFO between the register block and uart_tx: queues CPU bytes and hands
// them out one at a time as a held 32-bit word plus a one-cycle start pulse.
module uart_tx_fifo #(
  parameter int DEPTH  = 16,
  parameter int DATA_W = 8,
  parameter int LVL_W  = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic              flush_i,
  input  logic              clr_overflow_i,
  output logic              full_o,
  output logic              empty_o,
  output logic [LVL_W-1:0]  level_o,
  output logic              overflow_o,
  output logic              tx_busy_o,
  output logic [31:0]       tx_data_o,
  output logic              start_tx_o,
  input  logic              tx_done_i
);
  localparam int PTR_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    D_IDLE = 2'b00,
    D_ACK  = 2'b01,
    D_BUSY = 2'b10
  } state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]  level_q, level_d;
  logic              full_q, full_d;
  logic              empty_q, empty_d;
  logic              overflow_q, overflow_d;
  logic [31:0]       tx_data_q, tx_data_d;
  logic              start_q, start_d;
  state_t            state_q, state_d;

  logic push, pop, drop;

  // A pop is only ever issued by the drain FSM leaving D_IDLE; a pop frees a slot
  // for a same-cycle push even when full.
  always_comb begin
    pop  = (state_q == D_IDLE) && !empty_q && tx_done_i && !flush_i;
    push = wr_en_i && (!full_q || pop) && !flush_i;
    drop = wr_en_i && full_q && !pop && !flush_i;
  end

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      level_d  = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      level_d = level_q + LVL_W'(push) - LVL_W'(pop);
    end
    full_d  = (level_d == LVL_W'(DEPTH));
    empty_d = (level_d == '0);
    if (drop)                overflow_d = 1'b1;
    else if (clr_overflow_i) overflow_d = 1'b0;
  end

  always_comb begin
    state_d   = state_q;
    tx_data_d = tx_data_q;
    start_d   = 1'b0;
    case (state_q)
      D_IDLE: begin
        if (pop) begin
          tx_data_d = 32'(mem_q[rd_ptr_q]);
          start_d   = 1'b1;
          state_d   = D_ACK;
        end
      end
      D_ACK:   if (!tx_done_i) state_d = D_BUSY;
      D_BUSY:  if (tx_done_i)  state_d = D_IDLE;
      default: state_d = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
      tx_data_q  <= '0;
      start_q    <= 1'b0;
      state_q    <= D_IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      full_q     <= full_d;
      empty_q    <= empty_d;
      overflow_q <= overflow_d;
      tx_data_q  <= tx_data_d;
      start_q    <= start_d;
      state_q    <= state_d;
    end
  end

  // Storage needs no reset: a slot is only read after a push has filled it.
  always_ff @(posedge clk) begin
    if (!rst && push) mem_q[wr_ptr_q] <= wr_data_i;
  end

  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign level_o    = level_q;
  assign overflow_o = overflow_q;
  assign tx_data_o  = tx_data_q;
  assign start_tx_o = start_q;
  assign tx_busy_o  = (state_q != D_IDLE);

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: directed scenarios plus a random stream, every cycle compared
// against a queue-based reference of the FIFO and its start/done handshake.
module tb_uart_tx_fifo;
  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        wr_en_i = 1'b0;
  logic [7:0]  wr_data_i = '0;
  logic        flush_i = 1'b0;
  logic        clr_overflow_i = 1'b0;
  logic        tx_done_i = 1'b1;
  logic        full_o, empty_o, overflow_o, tx_busy_o, start_tx_o;
  logic [4:0]  level_o;
  logic [31:0] tx_data_o;

  uart_tx_fifo #(.DEPTH(DEPTH), .DATA_W(8)) dut (
    .clk(clk), .rst(rst), .wr_en_i(wr_en_i), .wr_data_i(wr_data_i),
    .flush_i(flush_i), .clr_overflow_i(clr_overflow_i),
    .full_o(full_o), .empty_o(empty_o), .level_o(level_o),
    .overflow_o(overflow_o), .tx_busy_o(tx_busy_o), .tx_data_o(tx_data_o),
    .start_tx_o(start_tx_o), .tx_done_i(tx_done_i)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference: queued bytes, the byte handed to the transmitter, and where the
  // handshake stands (0 = free, 1 = waiting for done to drop, 2 = waiting for done to rise).
  logic [7:0]  q[$];
  logic [7:0]  emitted[$];
  logic [7:0]  dut_out[$];
  int          phase = 0;
  logic [31:0] m_data = '0;
  logic        m_start = 1'b0;
  logic        m_ovf = 1'b0;
  int          u_cnt = 0;
  int          max_lvl = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_edge(input logic we, input logic [7:0] wd, input logic fl,
                            input logic clr, input logic done, input logic rs);
    logic pop, push, drop, full;
    if (rs) begin
      q.delete();
      phase = 0; m_data = '0; m_start = 1'b0; m_ovf = 1'b0;
      return;
    end
    full = (q.size() == DEPTH);
    pop  = (phase == 0) && (q.size() != 0) && done && !fl;
    push = we && (!full || pop) && !fl;
    drop = we && full && !pop && !fl;
    if (pop) begin
      m_data = {24'h0, q.pop_front()};
      emitted.push_back(m_data[7:0]);
    end
    if (push) q.push_back(wd);
    if (fl) q.delete();
    m_start = pop;
    if (drop) m_ovf = 1'b1;
    else if (clr) m_ovf = 1'b0;
    case (phase)
      0: if (pop) phase = 1;
      1: if (!done) phase = 2;
      default: if (done) phase = 0;
    endcase
  endtask

  task automatic check_all();
    chk("level", 32'(level_o), 32'(q.size()));
    chk("full", 32'(full_o), 32'(q.size() == DEPTH));
    chk("empty", 32'(empty_o), 32'(q.size() == 0));
    chk("overflow", 32'(overflow_o), 32'(m_ovf));
    chk("tx_busy", 32'(tx_busy_o), 32'(phase != 0));
    chk("tx_data", tx_data_o, m_data);
    chk("start_tx", 32'(start_tx_o), 32'(m_start));
  endtask

  task automatic step(input logic we, input logic [7:0] wd, input logic fl,
                      input logic clr, input logic done, input logic rs);
    wr_en_i = we; wr_data_i = wd; flush_i = fl;
    clr_overflow_i = clr; tx_done_i = done; rst = rs;
    @(posedge clk);
    model_edge(we, wd, fl, clr, done, rs);
    #1;
    if (start_tx_o) dut_out.push_back(tx_data_o[7:0]);
    if (int'(level_o) > max_lvl) max_lvl = int'(level_o);
    check_all();
  endtask

  // Transmitter stand-in: drops done right after a start, raises it a random time later.
  task automatic ustep(input logic we, input logic [7:0] wd);
    step(we, wd, 1'b0, 1'b0, (u_cnt == 0), 1'b0);
    if (m_start) u_cnt = $urandom_range(4, 1);
    else if (u_cnt > 0) u_cnt--;
  endtask

  initial begin
    // 1: reset, single byte latency and hold through the handshake
    step(0, 8'h00, 0, 0, 1, 1);
    step(0, 8'h00, 0, 0, 1, 1);
    step(1, 8'hA5, 0, 0, 1, 0);
    chk("s1_not_empty", 32'(empty_o), 32'd0);
    step(0, 8'h00, 0, 0, 1, 0);
    chk("s1_start", 32'(start_tx_o), 32'd1);
    chk("s1_data", tx_data_o, 32'h0000_00A5);
    for (int i = 0; i < 4; i++) step(0, 8'h00, 0, 0, 0, 0);
    chk("s1_hold", tx_data_o, 32'h0000_00A5);
    step(0, 8'h00, 0, 0, 1, 0);
    step(0, 8'h00, 0, 0, 1, 0);

    // 2: fill to full, drop the 17th, drain in order
    for (int i = 1; i <= 17; i++) step(1, 8'(i), 0, 0, 0, 0);
    chk("s2_full", 32'(full_o), 32'd1);
    chk("s2_ovf", 32'(overflow_o), 32'd1);
    step(0, 8'h00, 0, 1, 0, 0);
    dut_out.delete();
    u_cnt = 0;
    for (int i = 0; i < 200; i++) ustep(0, 8'h00);
    chk("s2_count", 32'(dut_out.size()), 32'd16);
    for (int i = 0; i < dut_out.size() && i < 16; i++) chk("s2_order", 32'(dut_out[i]), 32'(i + 1));

    // 3: push and pop together while full
    for (int i = 0; i < 16; i++) step(1, 8'(8'h60 + i), 0, 0, 0, 0);
    step(1, 8'h55, 0, 0, 1, 0);
    chk("s3_level", 32'(level_o), 32'd16);
    chk("s3_ovf", 32'(overflow_o), 32'd0);
    dut_out.delete();
    u_cnt = 1;
    for (int i = 0; i < 200; i++) ustep(0, 8'h00);
    chk("s3_last", (dut_out.size() > 0) ? 32'(dut_out[$]) : 32'hFFFF, 32'h55);

    // 4: flush with a byte in flight and a same-cycle push
    for (int i = 0; i < 5; i++) step(1, 8'(8'hB0 + i), 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    step(1, 8'h99, 1, 0, 0, 0);
    chk("s4_empty", 32'(empty_o), 32'd1);
    dut_out.delete();
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 0, 0);
    chk("s4_hold", tx_data_o, 32'h0000_00B0);
    for (int i = 0; i < 5; i++) step(0, 8'h00, 0, 0, 1, 0);
    chk("s4_no_start", 32'(dut_out.size()), 32'd0);

    // 5: random-rate stream of 40 bytes across pointer wrap
    begin
      int idx = 0;
      dut_out.delete();
      u_cnt = 0;
      max_lvl = 0;
      for (int c = 0; c < 3000 && dut_out.size() < 40; c++) begin
        if (idx < 40 && q.size() < DEPTH && $urandom_range(2, 0) != 0) begin
          ustep(1, 8'(idx));
          idx++;
        end else begin
          ustep(0, 8'h00);
        end
      end
      chk("s5_count", 32'(dut_out.size()), 32'd40);
      for (int i = 0; i < dut_out.size(); i++) chk("s5_order", 32'(dut_out[i]), 32'(i));
      chk("s5_max_level", 32'(max_lvl <= DEPTH), 32'd1);
    end
    for (int i = 0; i < 10; i++) ustep(0, 8'h00);

    // 6: reset in D_BUSY with bytes queued, then overflow set beats clear
    for (int i = 0; i < 4; i++) step(1, 8'(8'hC0 + i), 0, 0, 0, 0);
    step(0, 8'h00, 0, 0, 1, 0);
    step(0, 8'h00, 0, 0, 0, 0);
    chk("s6_busy", 32'(tx_busy_o), 32'd1);
    step(0, 8'h00, 0, 0, 0, 1);
    chk("s6_rst_data", tx_data_o, 32'd0);
    chk("s6_rst_empty", 32'(empty_o), 32'd1);
    dut_out.delete();
    for (int i = 0; i < 3; i++) step(0, 8'h00, 0, 0, 1, 0);
    chk("s6_no_start", 32'(dut_out.size()), 32'd0);
    for (int i = 0; i < 16; i++) step(1, 8'(i), 0, 0, 0, 0);
    step(1, 8'hEE, 0, 1, 0, 0);
    chk("s6_set_wins", 32'(overflow_o), 32'd1);
    step(0, 8'h00, 0, 1, 0, 0);
    chk("s6_clr", 32'(overflow_o), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
